// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser and the upstream vending FSM.
// Holds the dispenser state encoding, the change codes and the request entry layout.
package change_dispenser_pkg;

  localparam int unsigned REQ_W = 3;

  // Change codes driven by the vending FSM on change[1:0]
  localparam logic [1:0] CHG_NONE = 2'b00;
  localparam logic [1:0] CHG_1    = 2'b01;
  localparam logic [1:0] CHG_2    = 2'b10;
  localparam logic [1:0] CHG_3    = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    VEND     = 2'd1,
    HOP_ON   = 2'd2,
    HOP_WAIT = 2'd3
  } state_e;

  // One queued dispense request
  typedef struct packed {
    logic       vend;
    logic [1:0] chg;
  } req_t;

  // Number of 1 Rs coins owed for a change code
  function automatic logic [1:0] chg_to_coins(input logic [1:0] chg);
    logic [1:0] coins;
    coins = 2'd0;
    case (chg)
      CHG_1:   coins = 2'd1;
      CHG_2:   coins = 2'd2;
      CHG_3:   coins = 2'd3;
      default: coins = 2'd0;
    endcase
    return coins;
  endfunction

endpackage

// File: rtl/change_dispenser_req_fifo.sv
// req_fifo: small synchronous FIFO for dispense requests.
// Ports: clk, rst (async, active-high); push/wdata write side; pop/rdata read side
// (rdata is the head entry, valid while not empty); full/empty are registered flags;
// empty_nxt_c is the combinational value empty will take at the next edge.
// A push while full is accepted only if a pop happens in the same cycle.
module req_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             empty_nxt_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_nxt;
  logic [PW-1:0]    rd_nxt;
  logic             wr_en;
  logic             rd_en;

  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  // Next pointers; the top bit is the wrap flag that separates full from empty
  always_comb begin
    wr_nxt = wr_ptr + PW'(wr_en);
    rd_nxt = rd_ptr + PW'(rd_en);
  end

  assign empty_nxt_c = (wr_nxt == rd_nxt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      empty  <= (wr_nxt == rd_nxt);
      full   <= (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
    end
  end

  // Storage needs no reset: pointers define validity
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: queues vend/refund pulses from the vending FSM and drives the
// product solenoid and coin hopper, one request at a time in arrival order.
// Ports: clk, rst (async, active-high); vend_req, change_req[1:0] request pulses;
// coin_sense hopper exit pulse; solenoid, hopper_en actuators; busy, fifo_full status;
// err_jam, err_ovf sticky errors; coins_paid[15:0] confirmed coin count.
// Build option: define COIN_COUNTER_EN to implement coins_paid; otherwise it reads 0.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned VEND_CYCLES = 8,
  parameter int unsigned HOP_CYCLES  = 4,
  parameter int unsigned TIMEOUT     = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vend_req,
  input  logic [1:0]  change_req,
  input  logic        coin_sense,
  output logic        solenoid,
  output logic        hopper_en,
  output logic        busy,
  output logic        fifo_full,
  output logic        err_jam,
  output logic        err_ovf,
  output logic [15:0] coins_paid
);

  localparam int unsigned MAX_VH = (VEND_CYCLES > HOP_CYCLES) ? VEND_CYCLES : HOP_CYCLES;
  localparam int unsigned MAX_P  = (MAX_VH > TIMEOUT) ? MAX_VH : TIMEOUT;
  localparam int unsigned TW     = $clog2(MAX_P) + 1;

  state_e        state;
  logic          loaded;
  logic          vend_r;
  logic [1:0]    coins_left;
  logic          coin_seen;
  logic [TW-1:0] timer;

  req_t wreq;
  req_t rreq;
  logic fifo_empty;
  logic fifo_empty_nxt;
  logic push_c;
  logic pop_c;
  logic ovf_c;

  assign wreq   = '{vend: vend_req, chg: change_req};
  assign push_c = vend_req || (change_req != CHG_NONE);
  // Pop only from IDLE with nothing already loaded in the working registers
  assign pop_c  = (state == IDLE) && !loaded && !fifo_empty;
  assign ovf_c  = push_c && fifo_full && !pop_c;

  req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REQ_W)
  ) u_req_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push_c),
    .wdata       (wreq),
    .pop         (pop_c),
    .rdata       (rreq),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .empty_nxt_c (fifo_empty_nxt)
  );

  // Sequencer: load, vend, then one HOP_ON/HOP_WAIT pair per coin
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      loaded     <= 1'b0;
      vend_r     <= 1'b0;
      coins_left <= 2'd0;
      coin_seen  <= 1'b0;
      timer      <= '0;
      solenoid   <= 1'b0;
      hopper_en  <= 1'b0;
      busy       <= 1'b0;
      err_jam    <= 1'b0;
      err_ovf    <= 1'b0;
    end else begin
      busy <= 1'b1;
      if (ovf_c) err_ovf <= 1'b1;

      case (state)
        IDLE: begin
          timer     <= '0;
          coin_seen <= 1'b0;
          if (loaded) begin
            loaded <= 1'b0;
            if (vend_r) begin
              state    <= VEND;
              solenoid <= 1'b1;
            end else if (coins_left != 2'd0) begin
              state     <= HOP_ON;
              hopper_en <= 1'b1;
            end else begin
              busy <= !fifo_empty_nxt;
            end
          end else if (pop_c) begin
            loaded     <= 1'b1;
            vend_r     <= rreq.vend;
            coins_left <= chg_to_coins(rreq.chg);
          end else begin
            busy <= !fifo_empty_nxt;
          end
        end

        VEND: begin
          if (timer == TW'(VEND_CYCLES - 1)) begin
            timer    <= '0;
            solenoid <= 1'b0;
            if (coins_left != 2'd0) begin
              state     <= HOP_ON;
              hopper_en <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= !fifo_empty_nxt;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end

        HOP_ON: begin
          // An early sense is held and honoured on the first HOP_WAIT cycle
          if (coin_sense) coin_seen <= 1'b1;
          if (timer == TW'(HOP_CYCLES - 1)) begin
            timer     <= '0;
            hopper_en <= 1'b0;
            state     <= HOP_WAIT;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        HOP_WAIT: begin
          if (coin_seen) begin
            // Consuming the coin wins over any pulse in this cycle
            coin_seen  <= 1'b0;
            timer      <= '0;
            coins_left <= coins_left - 2'd1;
            if (coins_left > 2'd1) begin
              state     <= HOP_ON;
              hopper_en <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= !fifo_empty_nxt;
            end
          end else if (timer == TW'(TIMEOUT - 1)) begin
            // Jam: abandon the rest of this refund, keep serving the queue
            err_jam    <= 1'b1;
            coins_left <= 2'd0;
            timer      <= '0;
            state      <= IDLE;
            busy       <= !fifo_empty_nxt;
          end else begin
            timer <= timer + TW'(1);
            if (coin_sense) coin_seen <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef COIN_COUNTER_EN
  logic coin_take_c;

  assign coin_take_c = (state == HOP_WAIT) && coin_seen;

  // Saturating count of confirmed coins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coins_paid <= 16'd0;
    end else if (coin_take_c && (coins_paid != 16'hFFFF)) begin
      coins_paid <= coins_paid + 16'd1;
    end
  end
`else
  assign coins_paid = 16'd0;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Testbench for change_dispenser: a queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_change_dispenser;

  localparam int DEPTH    = 4;
  localparam int VEND_CYC = 8;
  localparam int HOP_CYC  = 4;
  localparam int TMO      = 32;
`ifdef COIN_COUNTER_EN
  localparam int PAY = 1;
`else
  localparam int PAY = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vend_req = 1'b0;
  logic [1:0]  change_req = 2'b00;
  logic        coin_sense = 1'b0;
  logic        solenoid;
  logic        hopper_en;
  logic        busy;
  logic        fifo_full;
  logic        err_jam;
  logic        err_ovf;
  logic [15:0] coins_paid;

  change_dispenser #(
    .DEPTH       (DEPTH),
    .VEND_CYCLES (VEND_CYC),
    .HOP_CYCLES  (HOP_CYC),
    .TIMEOUT     (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .vend_req   (vend_req),
    .change_req (change_req),
    .coin_sense (coin_sense),
    .solenoid   (solenoid),
    .hopper_en  (hopper_en),
    .busy       (busy),
    .fifo_full  (fifo_full),
    .err_jam    (err_jam),
    .err_ovf    (err_ovf),
    .coins_paid (coins_paid)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: request queue plus the job being served
  // phase: 0 idle, 1 product release, 2 hopper driving, 3 waiting for a coin
  bit [2:0] mq[$];
  int m_phase = 0;
  int m_rem   = 0;
  int m_wait  = 0;
  int m_coins = 0;
  int m_paid  = 0;
  bit m_loaded = 0;
  bit m_vend   = 0;
  bit m_seen   = 0;
  bit m_jam    = 0;
  bit m_ovf    = 0;

  // Monitor statistics
  int cyc_n = 0;
  int sol_cyc = 0, hop_cyc = 0, sol_rise = 0, hop_rise = 0;
  int hop_fall_at = 0, jam_rise_at = 0, last_act = 0;

  bit auto_coin = 0;

  task automatic chk(input string nm, input int act, input int exp_v);
    total_cnt++;
    if (act == exp_v) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp_v, $time);
  endtask

  task automatic model_reset();
    mq.delete();
    m_phase = 0; m_rem = 0; m_wait = 0; m_coins = 0; m_paid = 0;
    m_loaded = 0; m_vend = 0; m_seen = 0; m_jam = 0; m_ovf = 0;
  endtask

  task automatic model_step();
    bit [2:0] e;
    int  size0;
    bit  pop;
    bit  push;
    size0 = mq.size();
    pop   = (m_phase == 0) && !m_loaded && (size0 > 0);
    push  = vend_req || (change_req != 2'b00);
    case (m_phase)
      0: begin
        if (m_loaded) begin
          m_loaded = 0;
          if (m_vend) begin m_phase = 1; m_rem = VEND_CYC; end
          else if (m_coins > 0) begin m_phase = 2; m_rem = HOP_CYC; m_seen = 0; end
        end else if (pop) begin
          e = mq.pop_front();
          m_vend = e[2];
          m_coins = int'(e[1:0]);
          m_loaded = 1;
        end
      end
      1: begin
        m_rem--;
        if (m_rem == 0) begin
          if (m_coins > 0) begin m_phase = 2; m_rem = HOP_CYC; m_seen = 0; end
          else m_phase = 0;
        end
      end
      2: begin
        if (coin_sense) m_seen = 1;
        m_rem--;
        if (m_rem == 0) begin m_phase = 3; m_wait = 0; end
      end
      default: begin
        if (m_seen) begin
          m_seen = 0;
          m_coins--;
          if (m_paid < 65535) m_paid = m_paid + PAY;
          if (m_coins > 0) begin m_phase = 2; m_rem = HOP_CYC; end
          else m_phase = 0;
        end else if (m_wait == TMO - 1) begin
          m_jam = 1; m_coins = 0; m_phase = 0;
        end else begin
          m_wait++;
          if (coin_sense) m_seen = 1;
        end
      end
    endcase
    if (push) begin
      if (size0 < DEPTH || pop) mq.push_back({vend_req, change_req});
      else m_ovf = 1;
    end
  endtask

  task automatic model_loop();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  endtask

  // Per-cycle comparison against the model, sampled mid-cycle
  task automatic monitor_loop();
    logic sol_d = 0, hop_d = 0, jam_d = 0;
    forever begin
      @(negedge clk);
      cyc_n++;
      chk("solenoid",   solenoid,   (m_phase == 1) ? 1 : 0);
      chk("hopper_en",  hopper_en,  (m_phase == 2) ? 1 : 0);
      chk("busy",       busy,       (m_phase != 0 || m_loaded || mq.size() != 0) ? 1 : 0);
      chk("fifo_full",  fifo_full,  (mq.size() == DEPTH) ? 1 : 0);
      chk("err_jam",    err_jam,    m_jam);
      chk("err_ovf",    err_ovf,    m_ovf);
      chk("coins_paid", coins_paid, m_paid);
      if (solenoid) sol_cyc++;
      if (hopper_en) hop_cyc++;
      if (solenoid && !sol_d) begin sol_rise++; last_act = 1; end
      if (hopper_en && !hop_d) begin hop_rise++; last_act = 2; end
      if (!hopper_en && hop_d) hop_fall_at = cyc_n;
      if (err_jam && !jam_d) jam_rise_at = cyc_n;
      sol_d = solenoid; hop_d = hopper_en; jam_d = err_jam;
    end
  endtask

  // Hopper exit sensor: one pulse in the third cycle after each hopper burst ends
  task automatic coin_loop();
    int   wcnt = -1;
    logic hd = 0;
    forever begin
      @(posedge clk); #2;
      coin_sense = 1'b0;
      if (auto_coin) begin
        if (hd && !hopper_en) wcnt = 0;
        else if (wcnt >= 0) wcnt++;
        if (wcnt == 2) begin coin_sense = 1'b1; wcnt = -1; end
      end else begin
        wcnt = -1;
      end
      hd = hopper_en;
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] c);
    @(posedge clk); #2;
    vend_req = v;
    change_req = c;
  endtask

  task automatic wait_idle(input int maxc, input string nm);
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    while (busy && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_idle_bound"}, busy, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int s0, h0, sr0, hr0, k, n;
    fork
      model_loop();
      monitor_loop();
      coin_loop();
    join_none

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_solenoid", solenoid, 0);
    chk("rst_hopper",   hopper_en, 0);
    chk("rst_busy",     busy, 0);
    chk("rst_paid",     coins_paid, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Vend only: latency 2 edges, solenoid 8 cycles, no hopper
    s0 = sol_cyc; h0 = hop_cyc;
    drive(1'b1, 2'b00);
    drive(1'b0, 2'b00);
    k = 0;
    while (k < 10) begin
      @(negedge clk);
      k++;
      if (solenoid) break;
    end
    chk("vend_latency", k - 1, 2);
    wait_idle(100, "vend");
    chk("vend_sol_cycles", sol_cyc - s0, 8);
    chk("vend_hop_cycles", hop_cyc - h0, 0);

    // Change 10 with coin sense: two 4-cycle hopper bursts
    auto_coin = 1;
    h0 = hop_cyc; hr0 = hop_rise; sr0 = sol_rise;
    drive(1'b0, 2'b10);
    drive(1'b0, 2'b00);
    wait_idle(200, "chg2");
    chk("chg2_bursts", hop_rise - hr0, 2);
    chk("chg2_hop_cycles", hop_cyc - h0, 8);
    chk("chg2_no_vend", sol_rise - sr0, 0);
    chk("chg2_paid", coins_paid, 2 * PAY);

    // Vend + change 10 with no coin: jam, then the queued vend still fires
    auto_coin = 0;
    s0 = sol_cyc; h0 = hop_cyc;
    drive(1'b1, 2'b10);
    drive(1'b1, 2'b00);
    drive(1'b0, 2'b00);
    wait_idle(300, "jam");
    chk("jam_flag", err_jam, 1);
    chk("jam_delay", jam_rise_at - hop_fall_at, 32);
    chk("jam_hop_cycles", hop_cyc - h0, 4);
    chk("jam_sol_cycles", sol_cyc - s0, 16);
    chk("jam_last_is_vend", last_act, 1);

    // Six change 01 pushes while busy: overflow, five coins
    auto_coin = 1;
    hr0 = hop_rise;
    repeat (6) drive(1'b0, 2'b01);
    drive(1'b0, 2'b00);
    #1;
    chk("ovf_full", fifo_full, 1);
    chk("ovf_flag", err_ovf, 1);
    wait_idle(600, "ovf");
    chk("ovf_coins", hop_rise - hr0, 5);
    chk("ovf_paid", coins_paid, 7 * PAY);

    // Push coincident with a pop while full: accepted, order kept
    do_reset();
    sr0 = sol_rise; hr0 = hop_rise;
    drive(1'b1, 2'b00);
    repeat (4) drive(1'b0, 2'b01);
    drive(1'b0, 2'b00);
    n = 0;
    while (!(m_phase == 0 && !m_loaded && mq.size() == DEPTH) && n < 60) begin
      @(posedge clk); #2;
      n++;
    end
    chk("pp_reached_full_idle", (n < 60) ? 1 : 0, 1);
    vend_req = 1'b1;
    drive(1'b0, 2'b00);
    #1;
    chk("pp_no_ovf_now", err_ovf, 0);
    wait_idle(600, "pp");
    chk("pp_no_ovf", err_ovf, 0);
    chk("pp_vends", sol_rise - sr0, 2);
    chk("pp_coins", hop_rise - hr0, 4);
    chk("pp_last_is_vend", last_act, 1);

    // Reset in the third solenoid cycle: immediate drop, queue lost
    do_reset();
    auto_coin = 0;
    drive(1'b1, 2'b00);
    drive(1'b0, 2'b01);
    drive(1'b0, 2'b00);
    k = 0;
    while (!solenoid && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("mid_sol_started", solenoid, 1);
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("mid_sol_drop", solenoid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_full", fifo_full, 0);
    sr0 = sol_rise; hr0 = hop_rise;
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid_no_vend", sol_rise - sr0, 0);
    chk("mid_no_coin", hop_rise - hr0, 0);
    chk("mid_idle", busy, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Downstream stage of the coin-accepting vending FSM.
- Consumes that FSM's single-cycle `out` (product vend) and `change[1:0]` (refund in Rs) pulses, and queues them as dispense requests in a small FIFO.
- Executes each request in order: first the product solenoid, then the hopper motor, which ejects one 1 Rs coin per confirmed coin-sense pulse.
- Sits between the vending FSM and the physical actuators.

Parameters:
- DEPTH, 4: request FIFO entries; power of 2, minimum 2.
- VEND_CYCLES, 8: clock cycles the product solenoid is held high per vend.
- HOP_CYCLES, 4: clock cycles hopper_en is held high per coin.
- TIMEOUT, 32: cycles allowed in HOP_WAIT for a coin_sense pulse before declaring a jam.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- vend_req  in  1  product dispense pulse from vending FSM (its `out`).
- change_req  in  2  refund amount in Rs from vending FSM; 00 = none.
- coin_sense  in  1  synchronous one-cycle pulse from the hopper exit sensor.
- solenoid  out  1  product release actuator.
- hopper_en  out  1  coin hopper motor drive.
- busy  out  1  high when FSM is not IDLE or the FIFO is non-empty.
- fifo_full  out  1  FIFO holds DEPTH entries.
- err_jam  out  1  sticky: a hopper timeout has occurred.
- err_ovf  out  1  sticky: a request was dropped because the FIFO was full.
- coins_paid  out  16  total coins confirmed by coin_sense (see Optional Feature).

Behaviour:
- Reset (async, rst=1): all outputs 0, FIFO empty, state IDLE, all counters 0. Reset mid-operation aborts immediately; solenoid and hopper_en drop in the same instant.
- Push:
  - Any cycle with vend_req=1 or change_req!=00 pushes entry {vend_req, change_req} (3 bits).
  - A 0/00 entry is never pushed.
  - Push while full with no same-cycle pop: entry is dropped and err_ovf is set.
  - Simultaneous push and pop while full: push is accepted.
- Pop:
  - FIFO pops only in IDLE when non-empty.
  - The popped entry loads working registers vend_r and coins_left (change value: 01→1 coin, 10→2, 11→3).
  - The FSM leaves IDLE on the next edge.
- FSM states, evaluated after load:
  - IDLE → VEND if vend_r=1; else → HOP_ON if coins_left>0.
  - VEND: solenoid=1 for exactly VEND_CYCLES cycles, then → HOP_ON if coins_left>0, else → IDLE.
  - HOP_ON: hopper_en=1 for exactly HOP_CYCLES cycles, then → HOP_WAIT.
  - HOP_WAIT: hopper_en=0; timer counts up from 0.
- Coin-sense handling:
  - A coin_sense pulse in HOP_ON or HOP_WAIT is latched as coin_seen.
  - When in HOP_WAIT with coin_seen set: coins_left decrements and coin_seen clears; then → HOP_ON if coins_left>0, else → IDLE. An early sense (during HOP_ON) is honoured on the first HOP_WAIT cycle.
  - coin_sense in IDLE or VEND is ignored.
  - Only one coin is counted per HOP_ON/HOP_WAIT pair; extra pulses are ignored.
- Jam:
  - If the HOP_WAIT timer reaches TIMEOUT-1 with no coin_seen: set err_jam, discard remaining coins_left, → IDLE.
  - Later FIFO entries are still served.
- Sticky errors: err_jam and err_ovf clear only on rst.
- Latency: a request pushed into an empty FIFO in IDLE asserts its first actuator exactly 2 edges after the push edge (push, pop/load, then state entry).
- Widths: timers sized to $clog2 of the largest parameter plus 1; FIFO pointers carry an extra wrap bit for the full/empty distinction.

Optional Feature:
- Macro: COIN_COUNTER_EN.
- Defined: coins_paid increments on every accepted coin decrement; saturates at 16'hFFFF; reset to 0.
- Undefined: coins_paid is tied to 0 and no counter flops are synthesised.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE, VEND, HOP_ON, HOP_WAIT);
  - the change code constants (CHG_NONE=00, CHG_1=01, CHG_2=10) also used by the vending FSM;
  - request entry width (3).
- One sub-module: req_fifo (parameterised DEPTH, WIDTH; push/pop/full/empty), instantiated once.

Test Plan:
- Reset mid-VEND (cycle 3 of 8):
  - required: solenoid falls immediately; busy=0; queued entries lost.
- vend_req=1, change_req=00 in one cycle:
  - required: solenoid high exactly 8 cycles starting 2 edges after the push; hopper_en never asserted; busy falls the cycle after.
- change_req=10 only, with coin_sense pulsed 2 cycles into each HOP_WAIT:
  - required: two hopper_en bursts of 4 cycles; coins_paid=2 (macro defined) or 0 (undefined).
- vend+change=10 with no coin_sense:
  - required: solenoid 8 cycles; hopper_en 4 cycles; err_jam set 32 cycles later.
  - required: the following queued vend-only request still fires its solenoid.
- Six back-to-back change_req=01 pushes while the FSM is busy (DEPTH=4):
  - required: fifo_full=1; err_ovf=1; exactly 5 coins dispensed (1 in progress + 4 queued).
- Push on the same cycle as a pop with FIFO full:
  - required: no err_ovf; entry order preserved.
